// File: rtl/nsr_vec.sv
// Neuron state vector: DEPTH x WIDTH state entries with single or burst writes,
// a threshold register, and a combinational signed spike compare on the read port.
module nsr_vec #(
    parameter int unsigned      WIDTH   = 32,
    parameter int unsigned      DEPTH   = 32,
    parameter logic [WIDTH-1:0] VT_INIT = '0,
    localparam int unsigned     AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [1:0]       VL,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             we1,
    input  logic [WIDTH-1:0] wd1,
    input  logic [AW-1:0]    ra,
    output logic [WIDTH-1:0] rd,
    output logic             spike,
    output logic             busy,
    output logic             done,
    output logic             vl_err
);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [3:0]       beat_q, beat_d;
    logic [3:0]       last_q, last_d;
    logic [AW-1:0]    base_q, base_d;
    logic             done_q, done_d;
    logic             vl_err_q, vl_err_d;
    logic [WIDTH-1:0] vt_q, vt_d;
    logic [WIDTH-1:0] cur_q [DEPTH];
    logic [WIDTH-1:0] cur_d [DEPTH];

    logic             wr_en;
    logic [AW-1:0]    wr_addr;

    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        last_d   = last_q;
        base_d   = base_q;
        done_d   = 1'b0;
        vl_err_d = vl_err_q;
        wr_en    = 1'b0;
        wr_addr  = wa;

        unique case (state_q)
            IDLE: begin
                if (we) begin
                    wr_en   = 1'b1;
                    wr_addr = wa;
                    base_d  = wa;
                    beat_d  = 4'd1;
                    unique case (VL)
                        2'b00: done_d = 1'b1;
                        2'b01: begin
                            state_d = BURST;
                            last_d  = 4'd3;
                        end
                        2'b10: begin
                            state_d = BURST;
                            last_d  = 4'd15;
                        end
                        2'b11: begin
                            done_d   = 1'b1;
                            vl_err_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            BURST: begin
                // Modulo-DEPTH wrap falls out of the AW-bit add; a 16-beat burst
                // into a smaller array simply overwrites earlier beats.
                if (we) begin
                    wr_en   = 1'b1;
                    wr_addr = base_q + AW'(beat_q);
                    beat_d  = beat_q + 4'd1;
                    if (beat_q == last_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cur_d = cur_q;
        if (wr_en) begin
            cur_d[wr_addr] = wd;
        end
    end

    always_comb begin
        vt_d = vt_q;
        if (we1) begin
            vt_d = wd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            beat_q   <= '0;
            last_q   <= '0;
            base_q   <= '0;
            done_q   <= 1'b0;
            vl_err_q <= 1'b0;
            vt_q     <= VT_INIT;
            cur_q    <= '{default: '0};
        end else begin
            state_q  <= state_d;
            beat_q   <= beat_d;
            last_q   <= last_d;
            base_q   <= base_d;
            done_q   <= done_d;
            vl_err_q <= vl_err_d;
            vt_q     <= vt_d;
            cur_q    <= cur_d;
        end
    end

    assign rd     = cur_q[ra];
    assign spike  = $signed(rd) >= $signed(vt_q);
    assign busy   = (state_q == BURST);
    assign done   = done_q;
    assign vl_err = vl_err_q;

endmodule

// File: tb/tb_nsr_vec.sv
// Scoreboard bench for nsr_vec: expected entries are queued as beats are driven
// and compared against the read port once each transaction has completed.
module tb_nsr_vec;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             we;
    logic [1:0]       VL;
    logic [AW-1:0]    wa;
    logic [WIDTH-1:0] wd;
    logic             we1;
    logic [WIDTH-1:0] wd1;
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;
    logic             spike;
    logic             busy;
    logic             done;
    logic             vl_err;

    typedef struct {
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   busy_cnt;
    int   done_cnt;

    nsr_vec #(
        .WIDTH  (WIDTH),
        .DEPTH  (DEPTH),
        .VT_INIT(WIDTH'(0))
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (we),
        .VL    (VL),
        .wa    (wa),
        .wd    (wd),
        .we1   (we1),
        .wd1   (wd1),
        .ra    (ra),
        .rd    (rd),
        .spike (spike),
        .busy  (busy),
        .done  (done),
        .vl_err(vl_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Last write to an address wins, so an older pending entry is superseded.
    task automatic push_exp(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        exp_t e;
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].addr == a) sb_q.delete(i);
        end
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb_q.size() > 0) begin
            e  = sb_q.pop_front();
            ra = e.addr;
            #1;
            check($sformatf("rd[%0d]", e.addr), rd, e.data);
        end
    endtask

    task automatic clk_step(input logic exp_busy, input logic exp_done);
        @(posedge clk);
        #1;
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        check("busy", WIDTH'(busy), WIDTH'(exp_busy));
        check("done", WIDTH'(done), WIDTH'(exp_done));
    endtask

    task automatic write_txn(input logic [1:0] vl, input int unsigned base,
                             input logic [WIDTH-1:0] d0, input int stall_after);
        int unsigned len;
        len = (vl == 2'b01) ? 4 : (vl == 2'b10) ? 16 : 1;
        for (int unsigned k = 0; k < len; k++) begin
            we = 1'b1;
            wd = d0 + WIDTH'(k);
            if (k == 0) begin
                VL = vl;
                wa = AW'(base);
            end else begin
                VL = 2'b11;
                wa = AW'($urandom);
            end
            push_exp(AW'((base + k) % DEPTH), d0 + WIDTH'(k));
            clk_step(k < len - 1, k == len - 1);
            if (int'(k) == stall_after) begin
                we = 1'b0;
                wd = '1;
                repeat (2) clk_step(1'b1, 1'b0);
            end
        end
        we = 1'b0;
        VL = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        we = 1'b0; VL = 2'b00; wa = '0; wd = '0;
        we1 = 1'b0; wd1 = '0; ra = '0;
        busy_cnt = 0; done_cnt = 0;

        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", WIDTH'(busy), '0);
        check("rst_done", WIDTH'(done), '0);
        check("rst_vl_err", WIDTH'(vl_err), '0);
        ra = AW'(7);
        #1;
        check("rst_rd7", rd, '0);
        check("rst_spike", WIDTH'(spike), WIDTH'(1));
        rst_n = 1'b1;

        // Single write; rd at the target must show the old value before the edge.
        we = 1'b1; VL = 2'b00; wa = AW'(5); wd = 32'h1234; ra = AW'(5);
        #1;
        check("rd_same_cycle", rd, '0);
        push_exp(AW'(5), 32'h1234);
        clk_step(1'b0, 1'b1);
        we = 1'b0;
        clk_step(1'b0, 1'b0);
        drain();

        // 4-beat burst wrapping at the top with a 2-cycle stall.
        busy_cnt = 0; done_cnt = 0;
        write_txn(2'b01, 30, 32'hA0, 1);
        clk_step(1'b0, 1'b0);
        check("burst4_busy_cycles", WIDTH'(busy_cnt), WIDTH'(5));
        check("burst4_done_pulses", WIDTH'(done_cnt), WIDTH'(1));
        drain();
        we1 = 1'b1; wd1 = 32'hA2;
        clk_step(1'b0, 1'b0);
        we1 = 1'b0;
        ra = AW'(0);
        #1;
        check("spike_eq", WIDTH'(spike), WIDTH'(1));
        ra = AW'(31);
        #1;
        check("spike_below", WIDTH'(spike), WIDTH'(0));

        // 16-beat burst followed back-to-back by a single write into it.
        busy_cnt = 0; done_cnt = 0;
        write_txn(2'b10, 0, 32'h100, -1);
        write_txn(2'b00, 3, 32'h7, -1);
        clk_step(1'b0, 1'b0);
        check("b2b_done_pulses", WIDTH'(done_cnt), WIDTH'(2));
        check("b2b_busy_cycles", WIDTH'(busy_cnt), WIDTH'(15));
        drain();

        // Signed threshold, loaded in the same cycle as a state write.
        we1 = 1'b1; wd1 = 32'hFFFF_FFF6;
        write_txn(2'b00, 2, 32'hFFFF_FFFB, -1);
        we1 = 1'b0;
        ra = AW'(2);
        #1;
        check("spike_neg_above", WIDTH'(spike), WIDTH'(1));
        write_txn(2'b00, 2, 32'h8000_0000, -1);
        ra = AW'(2);
        #1;
        check("spike_most_neg", WIDTH'(spike), WIDTH'(0));
        drain();
        check("vl_err_clear", WIDTH'(vl_err), '0);

        // Reset in the middle of a 16-beat burst.
        busy_cnt = 0; done_cnt = 0;
        for (int unsigned k = 0; k < 3; k++) begin
            we = 1'b1;
            VL = (k == 0) ? 2'b10 : 2'b00;
            wa = AW'(8);
            wd = 32'h55 + WIDTH'(k);
            clk_step(1'b1, 1'b0);
        end
        we = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", WIDTH'(busy), '0);
        check("midrst_done", WIDTH'(done), '0);
        for (int unsigned a = 0; a < DEPTH; a++) begin
            ra = AW'(a);
            #1;
            check($sformatf("midrst_rd[%0d]", a), rd, '0);
        end
        clk_step(1'b0, 1'b0);
        rst_n = 1'b1;
        check("midrst_done_pulses", WIDTH'(done_cnt), '0);

        // Reserved length code: single write plus sticky error.
        write_txn(2'b11, 4, 32'h9, -1);
        check("vl_err_set", WIDTH'(vl_err), WIDTH'(1));
        repeat (3) clk_step(1'b0, 1'b0);
        check("vl_err_sticky", WIDTH'(vl_err), WIDTH'(1));
        ra = AW'(4);
        #1;
        check("spike_vt_reset", WIDTH'(spike), WIDTH'(1));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
